// File: rtl/nbit_adder_pkg.sv
// Shared constants and a golden-arithmetic helper for the registered ripple adder.
// Optional signed-overflow output is enabled with NBIT_ADDER_OVF_EN.
package nbit_adder_pkg;

  localparam int NBIT_ADDER_DEFAULT_WIDTH = 8;
  localparam int NBIT_ADDER_MAX_WIDTH     = 64;

  // Callers keep bits [WIDTH:0]; bit WIDTH is the carry-out for that width.
  function automatic logic [NBIT_ADDER_MAX_WIDTH:0] ref_add(
    input logic [NBIT_ADDER_MAX_WIDTH-1:0] a,
    input logic [NBIT_ADDER_MAX_WIDTH-1:0] b,
    input logic                            ci
  );
    return {1'b0, a} + {1'b0, b} + {{NBIT_ADDER_MAX_WIDTH{1'b0}}, ci};
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; one link of the ripple carry chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/nbit_reg_adder.sv
// Unsigned WIDTH-bit ripple-carry adder with registered sum/carry-out.
// Define NBIT_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module nbit_reg_adder
  import nbit_adder_pkg::*;
#(
  parameter int WIDTH = NBIT_ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef NBIT_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Interface has no valid/ready: every clock accepts a new operand pair and
  // the matching result is on the outputs exactly one rising edge later.

  wire  [WIDTH:0]   c;
  logic [WIDTH-1:0] s_comb;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s_comb[i]),
      .co (c[i+1])
    );
  end

`ifdef NBIT_ADDER_OVF_EN
  // Carry into and out of the sign bit disagree exactly on signed overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      sum   <= s_comb;
      carry <= c[WIDTH];
      ovf   <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      sum   <= s_comb;
      carry <= c[WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_nbit_reg_adder.sv
// Self-checking bench for nbit_reg_adder (WIDTH=8), with or without NBIT_ADDER_OVF_EN.
module tb_nbit_reg_adder;

  localparam int W  = 8;
  localparam int EW = W + 2;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic [W-1:0] sum;
  logic         carry;
`ifdef NBIT_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];

  nbit_reg_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .sum   (sum),
    .carry (carry)
`ifdef NBIT_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] observed();
    logic o;
`ifdef NBIT_ADDER_OVF_EN
    o = ovf;
`else
    o = 1'b0;
`endif
    return {o, carry, sum};
  endfunction

  // Reference model: integer arithmetic on the operand values, {ovf, carry, sum}.
  function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mci);
    longint total, sa, sb, sres, modv, half;
    logic [W-1:0] s;
    logic cy, ov;
    modv  = longint'(1) << W;
    half  = longint'(1) << (W - 1);
    total = longint'(ma) + longint'(mb) + longint'(mci);
    s     = W'(total % modv);
    cy    = (total >= modv);
    sa    = (longint'(ma) >= half) ? longint'(ma) - modv : longint'(ma);
    sb    = (longint'(mb) >= half) ? longint'(mb) - modv : longint'(mb);
    sres  = sa + sb + longint'(mci);
`ifdef NBIT_ADDER_OVF_EN
    ov    = (sres > half - 1) || (sres < -half);
`else
    ov    = 1'b0;
`endif
    return {ov, cy, s};
  endfunction

  // Scoreboard: one expected entry per driven cycle, due one edge later.
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("result", 64'(observed()), 64'(e));
    end
  end

  // ---------------- driver ----------------
  task automatic drive_op(input logic [W-1:0] da, input logic [W-1:0] db, input logic dci);
    @(negedge clk);
    a  = da;
    b  = db;
    ci = dci;
    exp_q.push_back(model(da, db, dci));
  endtask

  task automatic drive_rand(input logic dci);
    drive_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)), dci);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    ci  = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("reset_async_sum", 64'(sum), 64'd0);
    check("reset_async_carry", 64'(carry), 64'd0);
`ifdef NBIT_ADDER_OVF_EN
    check("reset_async_ovf", 64'(ovf), 64'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 64'(observed()), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    drive_op(8'd200, 8'd100, 1'b0);
    drive_op(8'd255, 8'd0,   1'b1);
    drive_op(8'd0,   8'd0,   1'b0);
    drive_op(8'd255, 8'd255, 1'b1);
    drive_op(8'd15,  8'd16,  1'b1);
    drive_op(8'd127, 8'd1,   1'b0);
    drive_op(8'd128, 8'd128, 1'b0);
    drive_op(8'd100, 8'd27,  1'b0);
    drive_op(8'd128, 8'd255, 1'b1);

    // back-to-back random stream, no idle cycles
    for (int i = 0; i < 12; i++) drive_rand(1'b0);
    for (int i = 0; i < 12; i++) drive_rand(1'b1);
    for (int i = 0; i < 16; i++) drive_rand(1'($urandom_range(0, 1)));

    // mid-stream asynchronous reset between clock edges
    drive_op(8'd255, 8'd255, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midstream_reset", 64'(observed()), 64'd0);
    a = 8'hff; b = 8'hff; ci = 1'b1;
    @(posedge clk);
    #1;
    check("midstream_reset_hold", 64'(observed()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    a   = 8'd3;
    b   = 8'd4;
    ci  = 1'b1;
    exp_q.push_back(model(8'd3, 8'd4, 1'b1));
    for (int i = 0; i < 8; i++) drive_rand(1'($urandom_range(0, 1)));

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
